// File: rtl/fir_sweep_meter_pkg.sv
// Shared types and default parameters for the FIR sweep response meter.
package fir_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        MEASURE,
        REPORT
    } meter_state_t;

    localparam int DEF_DATA_WIDTH    = 16;
    localparam int DEF_STEP_WIDTH    = 32;
    localparam int DEF_SETTLE_CYCLES = 64;
    localparam int DEF_WINDOW_CYCLES = 400;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fir_sweep_meter_if.sv
// Sample stream, step marker and measurement results of the sweep meter.
interface fir_sweep_meter_if
    import fir_meter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int STEP_WIDTH = DEF_STEP_WIDTH
);
    logic                  i_step_start;
    logic [STEP_WIDTH-1:0] i_phase_step;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  o_busy;
    logic                  o_valid;
    logic [STEP_WIDTH-1:0] o_phase_step;
    logic [DATA_WIDTH-1:0] o_max;
    logic [DATA_WIDTH-1:0] o_min;
    logic [DATA_WIDTH:0]   o_amplitude;

    modport master (
        output i_step_start, i_phase_step, i_data,
        input  o_busy, o_valid, o_phase_step, o_max, o_min, o_amplitude
    );

    modport slave (
        input  i_step_start, i_phase_step, i_data,
        output o_busy, o_valid, o_phase_step, o_max, o_min, o_amplitude
    );
endinterface

// File: rtl/fir_sweep_meter_peak_tracker.sv
// Running signed max/min: load seeds both extremes, update widens them.
module peak_tracker #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic                         load,
    input  logic                         update,
    input  logic signed [DATA_WIDTH-1:0] data,
    output logic signed [DATA_WIDTH-1:0] max_val,
    output logic signed [DATA_WIDTH-1:0] min_val
);
    logic signed [DATA_WIDTH-1:0] max_reg;
    logic signed [DATA_WIDTH-1:0] min_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            max_reg <= '0;
            min_reg <= '0;
        end else if (load) begin
            max_reg <= data;
            min_reg <= data;
        end else if (update) begin
            if (data > max_reg) max_reg <= data;
            if (data < min_reg) min_reg <= data;
        end
    end

    assign max_val = max_reg;
    assign min_val = min_reg;
endmodule

// File: rtl/fir_sweep_meter.sv
// Per-step settle/measure/report sequencer producing peak-to-peak amplitude
// tagged with the phase increment of each sweep step.
module fir_sweep_meter
    import fir_meter_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int STEP_WIDTH    = DEF_STEP_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES
) (
    input  logic              i_clk,
    input  logic              i_rst,
    fir_sweep_meter_if.slave  bus
);
    localparam int CNT_W = $clog2(max_int(SETTLE_CYCLES, WINDOW_CYCLES) + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST =
        CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(WINDOW_CYCLES - 1);

    meter_state_t          state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [STEP_WIDTH-1:0] tag_reg, tag_next;
    logic                  load, update, report;

    logic signed [DATA_WIDTH-1:0] run_max, run_min;
    logic signed [DATA_WIDTH:0]   amp_next;

    logic                  valid_reg;
    logic [STEP_WIDTH-1:0] phase_out_reg;
    logic [DATA_WIDTH-1:0] max_reg, min_reg;
    logic [DATA_WIDTH:0]   amp_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        tag_next   = tag_reg;
        load       = 1'b0;
        update     = 1'b0;
        report     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.i_step_start) begin
                    tag_next   = bus.i_phase_step;
                    cnt_next   = '0;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (bus.i_step_start) begin
                    tag_next   = bus.i_phase_step;
                    cnt_next   = '0;
                    state_next = SETTLE;
                end else if (SETTLE_CYCLES == 0 || cnt_reg == SETTLE_LAST) begin
                    cnt_next   = '0;
                    state_next = MEASURE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            MEASURE: begin
                if (bus.i_step_start) begin
                    tag_next   = bus.i_phase_step;
                    cnt_next   = '0;
                    state_next = SETTLE;
                end else begin
                    // The first window sample seeds both extremes.
                    load   = (cnt_reg == '0);
                    update = (cnt_reg != '0);
                    if (cnt_reg == WINDOW_LAST) begin
                        cnt_next   = '0;
                        state_next = REPORT;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            REPORT: begin
                report     = 1'b1;
                state_next = IDLE;
                // A new step here still lets the finished step report first.
                if (bus.i_step_start) begin
                    tag_next   = bus.i_phase_step;
                    cnt_next   = '0;
                    state_next = SETTLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign amp_next = {run_max[DATA_WIDTH-1], run_max} - {run_min[DATA_WIDTH-1], run_min};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            tag_reg       <= '0;
            valid_reg     <= 1'b0;
            phase_out_reg <= '0;
            max_reg       <= '0;
            min_reg       <= '0;
            amp_reg       <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            tag_reg   <= tag_next;
            valid_reg <= report;
            if (report) begin
                phase_out_reg <= tag_reg;
                max_reg       <= run_max;
                min_reg       <= run_min;
                amp_reg       <= amp_next;
            end
        end
    end

    peak_tracker #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_peak (
        .clk     (i_clk),
        .srst    (i_rst),
        .load    (load),
        .update  (update),
        .data    ($signed(bus.i_data)),
        .max_val (run_max),
        .min_val (run_min)
    );

    assign bus.o_busy       = (state_reg == SETTLE) || (state_reg == MEASURE);
    assign bus.o_valid      = valid_reg;
    assign bus.o_phase_step = phase_out_reg;
    assign bus.o_max        = max_reg;
    assign bus.o_min        = min_reg;
    assign bus.o_amplitude  = amp_reg;
endmodule

// File: tb/tb_fir_sweep_meter.sv
// Directed bench for fir_sweep_meter with default timing (64 settle, 400 window).
module tb_fir_sweep_meter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fir_sweep_meter_if #(.DATA_WIDTH(16), .STEP_WIDTH(32)) bus ();

    fir_sweep_meter #(
        .DATA_WIDTH    (16),
        .STEP_WIDTH    (32),
        .SETTLE_CYCLES (64),
        .WINDOW_CYCLES (400)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", nm, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after an edge; outputs are read at the same point.
    task automatic cyc(input logic [15:0] d, input logic s, input logic [31:0] t);
        bus.i_data       = d;
        bus.i_step_start = s;
        bus.i_phase_step = t;
        @(posedge clk);
        #1;
        bus.i_step_start = 1'b0;
    endtask

    // k counts edges from the step_start edge; window is k = 65..464.
    function automatic logic [15:0] sample(input int mode, input int k);
        case (mode)
            0: return 16'd1000;
            1: return ((k % 10) < 5) ? 16'd12000 : 16'(-12000);
            2: begin
                if (k == 64 || k == 465) return 16'h8000;
                if (k == 200) return 16'h7FFF;
                return 16'd100;
            end
            default: begin
                if (k == 65) return 16'h8000;
                if (k == 464) return 16'h7FFF;
                return 16'd0;
            end
        endcase
    endfunction

    task automatic chk_zero(input string nm);
        chk({nm, "_busy"},  64'(bus.o_busy), 64'd0);
        chk({nm, "_valid"}, 64'(bus.o_valid), 64'd0);
        chk({nm, "_tag"},   64'(bus.o_phase_step), 64'd0);
        chk({nm, "_max"},   64'(bus.o_max), 64'd0);
        chk({nm, "_min"},   64'(bus.o_min), 64'd0);
        chk({nm, "_amp"},   64'(bus.o_amplitude), 64'd0);
    endtask

    task automatic measure(input int mode, input logic [31:0] tag, input bit issue_start,
                           input bit chain, input logic [31:0] next_tag,
                           input logic [15:0] emax, input logic [15:0] emin,
                           input logic [16:0] eamp, input string nm);
        int vbad;
        vbad = 0;
        if (issue_start) begin
            cyc(sample(mode, 0), 1'b1, tag);
            chk({nm, "_busy_rise"}, 64'(bus.o_busy), 64'd1);
        end
        for (int k = 1; k <= 464; k++) begin
            cyc(sample(mode, k), 1'b0, 32'h0);
            if (bus.o_valid !== 1'b0) vbad++;
            if (k == 463) chk({nm, "_busy_meas"}, 64'(bus.o_busy), 64'd1);
            if (k == 464) chk({nm, "_busy_fall"}, 64'(bus.o_busy), 64'd0);
        end
        chk({nm, "_early_valid"}, 64'(vbad), 64'd0);
        cyc(sample(mode, 465), chain, next_tag);
        chk({nm, "_valid"}, 64'(bus.o_valid), 64'd1);
        chk({nm, "_tag"},   64'(bus.o_phase_step), 64'(tag));
        chk({nm, "_max"},   64'(bus.o_max), 64'(emax));
        chk({nm, "_min"},   64'(bus.o_min), 64'(emin));
        chk({nm, "_amp"},   64'(bus.o_amplitude), 64'(eamp));
        chk({nm, "_busy_after"}, 64'(bus.o_busy), 64'(chain));
        if (!chain) begin
            cyc(16'd0, 1'b0, 32'h0);
            chk({nm, "_valid_pulse"}, 64'(bus.o_valid), 64'd0);
            chk({nm, "_amp_hold"},    64'(bus.o_amplitude), 64'(eamp));
            chk({nm, "_tag_hold"},    64'(bus.o_phase_step), 64'(tag));
        end
    endtask

    initial begin
        int vbad;
        int bbad;
        bus.i_data       = '0;
        bus.i_step_start = 1'b0;
        bus.i_phase_step = '0;

        rst = 1'b1;
        repeat (3) cyc(16'd0, 1'b0, 32'h0);
        chk_zero("reset");
        rst = 1'b0;
        cyc(16'd0, 1'b0, 32'h0);

        measure(0, 32'h000FFFFF, 1'b1, 1'b0, 32'h0, 16'd1000, 16'd1000, 17'd0, "dc");
        measure(1, 32'h00012345, 1'b1, 1'b0, 32'h0, 16'd12000, 16'(-12000), 17'd24000, "square");
        measure(2, 32'h00020000, 1'b1, 1'b0, 32'h0, 16'h7FFF, 16'd100, 17'd32667, "settle_excl");
        measure(3, 32'h00030000, 1'b1, 1'b0, 32'h0, 16'h7FFF, 16'h8000, 17'd65535, "fullscale");

        // Restart at edge 200, well inside the first step's window.
        vbad = 0;
        cyc(sample(1, 0), 1'b1, 32'h000AAAAA);
        for (int k = 1; k < 200; k++) begin
            cyc(sample(1, k), 1'b0, 32'h0);
            if (bus.o_valid !== 1'b0) vbad++;
        end
        chk("abort_no_report", 64'(vbad), 64'd0);
        measure(0, 32'h001FFFFF, 1'b1, 1'b0, 32'h0, 16'd1000, 16'd1000, 17'd0, "abort_second");

        // New step arrives on the REPORT cycle of the previous one.
        measure(1, 32'h00044444, 1'b1, 1'b1, 32'h00055555,
                16'd12000, 16'(-12000), 17'd24000, "chain_old");
        measure(0, 32'h00055555, 1'b0, 1'b0, 32'h0, 16'd1000, 16'd1000, 17'd0, "chain_new");

        // Reset mid-window; step_start during reset must be ignored.
        cyc(sample(1, 0), 1'b1, 32'h00066666);
        for (int k = 1; k <= 150; k++) cyc(sample(1, k), 1'b0, 32'h0);
        rst = 1'b1;
        cyc(16'd0, 1'b0, 32'h0);
        cyc(16'd0, 1'b1, 32'h00099999);
        rst = 1'b0;
        chk_zero("midreset");
        vbad = 0;
        bbad = 0;
        for (int k = 0; k < 470; k++) begin
            cyc(sample(1, k), 1'b0, 32'h0);
            if (bus.o_valid !== 1'b0) vbad++;
            if (bus.o_busy !== 1'b0) bbad++;
        end
        chk("midreset_no_valid", 64'(vbad), 64'd0);
        chk("midreset_idle", 64'(bbad), 64'd0);
        measure(2, 32'h00077777, 1'b1, 1'b0, 32'h0, 16'h7FFF, 16'd100, 17'd32667, "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
